// File: rtl/usb3_rx_lock_ctrl.sv
// USB 3.0 RX symbol-lock controller: classifies the descrambled word stream and
// runs a hunt/check/locked FSM with leaky-bucket error tolerance and an idle watchdog.
module usb3_rx_lock_ctrl #(
  parameter int LOCK_GOOD    = 8,
  parameter int UNLOCK_ERRS  = 4,
  parameter int LEAK_WORDS   = 16,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic        local_clk,
  input  logic        reset_n,
  input  logic        in_active,
  input  logic [3:0]  in_datak,
  input  logic [31:0] in_data,
  input  logic        skp_err,
  input  logic        stat_clr,
  output logic        rx_locked,
  output logic        realign,
  output logic        lock_lost,
  output logic [15:0] bad_word_cnt,
  output logic [1:0]  lock_state
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      r_state, w_nextState;
  logic [7:0]  r_goodCnt, w_nextGoodCnt;
  logic [3:0]  r_errBkt, w_nextErrBkt;
  logic [7:0]  r_leakCnt, w_nextLeakCnt;
  logic [15:0] r_idleCnt, w_nextIdleCnt;
  logic [15:0] r_badWordCnt, w_nextBadWordCnt;
  logic        r_rxLocked, r_realign, r_lockLost;
  logic        w_nextRealign, w_nextLockLost;

  logic w_kWord, w_legalK, w_com, w_good, w_bad, w_goodEv, w_comEv, w_idleHit;

  assign w_kWord  = (in_datak == 4'hF);
  assign w_legalK = (in_data == 32'hBCBCBCBC) || (in_data == 32'hFBFBFBF7) ||
                    (in_data == 32'h5C5C5CF7) || (in_data == 32'hFEFEFEF7) ||
                    (in_data == 32'hFDFDFDFE) || (in_data == 32'h7C7C7C7C);
  assign w_com    = in_active && w_kWord && (in_data == 32'hBCBCBCBC);
  assign w_good   = in_active && ((in_datak == 4'h0) || (w_kWord && w_legalK));
  // An SKP error spoils the whole cycle, so it masks any good/COM qualification.
  assign w_bad    = skp_err || (in_active && !w_good);
  assign w_goodEv = w_good && !skp_err;
  assign w_comEv  = w_com && !skp_err;
  assign w_idleHit = !in_active && (r_idleCnt == 16'(IDLE_TIMEOUT - 1));

  always_comb begin
    w_nextState      = r_state;
    w_nextGoodCnt    = r_goodCnt;
    w_nextErrBkt     = r_errBkt;
    w_nextLeakCnt    = r_leakCnt;
    w_nextIdleCnt    = r_idleCnt;
    w_nextBadWordCnt = r_badWordCnt;
    w_nextRealign    = 1'b0;
    w_nextLockLost   = 1'b0;

    if (r_state != HUNT) begin
      w_nextIdleCnt = in_active ? 16'd0 : r_idleCnt + 16'd1;
    end

    case (r_state)
      HUNT: begin
        if (w_comEv) begin
          w_nextState   = CHECK;
          w_nextGoodCnt = 8'd0;
          w_nextIdleCnt = 16'd0;
        end
      end
      CHECK: begin
        if (w_idleHit || w_bad) begin
          w_nextState   = HUNT;
          w_nextRealign = 1'b1;
        end else if (w_comEv) begin
          w_nextGoodCnt = 8'd1;
        end else if (w_goodEv) begin
          w_nextGoodCnt = r_goodCnt + 8'd1;
          if (r_goodCnt + 8'd1 == 8'(LOCK_GOOD)) begin
            w_nextState   = LOCKED;
            w_nextErrBkt  = 4'd0;
            w_nextLeakCnt = 8'd0;
          end
        end
      end
      LOCKED: begin
        if (w_idleHit || (w_bad && (r_errBkt + 4'd1 == 4'(UNLOCK_ERRS)))) begin
          w_nextState    = HUNT;
          w_nextRealign  = 1'b1;
          w_nextLockLost = 1'b1;
        end else if (w_bad) begin
          w_nextErrBkt  = r_errBkt + 4'd1;
          w_nextLeakCnt = 8'd0;
        end else if (w_goodEv) begin
          if (r_leakCnt + 8'd1 == 8'(LEAK_WORDS)) begin
            w_nextLeakCnt = 8'd0;
            if (r_errBkt != 4'd0) w_nextErrBkt = r_errBkt - 4'd1;
          end else begin
            w_nextLeakCnt = r_leakCnt + 8'd1;
          end
        end
      end
      default: w_nextState = HUNT;
    endcase

    // Leaving to HUNT always starts the next acquisition from clean counters.
    if (w_nextState == HUNT) begin
      w_nextGoodCnt = 8'd0;
      w_nextErrBkt  = 4'd0;
      w_nextLeakCnt = 8'd0;
      w_nextIdleCnt = 16'd0;
    end

    if (stat_clr) begin
      w_nextBadWordCnt = 16'd0;
    end else if (w_bad && (r_state != HUNT) && (r_badWordCnt != 16'hFFFF)) begin
      w_nextBadWordCnt = r_badWordCnt + 16'd1;
    end
  end

  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      r_state      <= HUNT;
      r_goodCnt    <= 8'd0;
      r_errBkt     <= 4'd0;
      r_leakCnt    <= 8'd0;
      r_idleCnt    <= 16'd0;
      r_badWordCnt <= 16'd0;
      r_rxLocked   <= 1'b0;
      r_realign    <= 1'b0;
      r_lockLost   <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_goodCnt    <= w_nextGoodCnt;
      r_errBkt     <= w_nextErrBkt;
      r_leakCnt    <= w_nextLeakCnt;
      r_idleCnt    <= w_nextIdleCnt;
      r_badWordCnt <= w_nextBadWordCnt;
      r_rxLocked   <= (w_nextState == LOCKED);
      r_realign    <= w_nextRealign;
      r_lockLost   <= w_nextLockLost;
    end
  end

  assign rx_locked    = r_rxLocked;
  assign realign      = r_realign;
  assign lock_lost    = r_lockLost;
  assign bad_word_cnt = r_badWordCnt;
  assign lock_state   = r_state;

endmodule

// File: tb/tb_usb3_rx_lock_ctrl.sv
// Directed bench for usb3_rx_lock_ctrl: drives words on the falling edge and
// checks registered outputs one falling edge later against hand-computed values.
module tb_usb3_rx_lock_ctrl;

  logic        local_clk;
  logic        reset_n;
  logic        in_active;
  logic [3:0]  in_datak;
  logic [31:0] in_data;
  logic        skp_err;
  logic        stat_clr;
  logic        rx_locked;
  logic        realign;
  logic        lock_lost;
  logic [15:0] bad_word_cnt;
  logic [1:0]  lock_state;

  int totalChecks = 0;
  int badChecks   = 0;

  localparam logic [31:0] COM_W = 32'hBCBCBCBC;

  usb3_rx_lock_ctrl dut (
    .local_clk   (local_clk),
    .reset_n     (reset_n),
    .in_active   (in_active),
    .in_datak    (in_datak),
    .in_data     (in_data),
    .skp_err     (skp_err),
    .stat_clr    (stat_clr),
    .rx_locked   (rx_locked),
    .realign     (realign),
    .lock_lost   (lock_lost),
    .bad_word_cnt(bad_word_cnt),
    .lock_state  (lock_state)
  );

  initial local_clk = 1'b0;
  always #5 local_clk = ~local_clk;

  // Present one word for one rising edge; returns on the following falling edge.
  task automatic applyStimulus(input logic act, input logic [3:0] k, input logic [31:0] d,
                               input logic skp, input logic clr);
    in_active = act;
    in_datak  = k;
    in_data   = d;
    skp_err   = skp;
    stat_clr  = clr;
    @(negedge local_clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sendCom();
    applyStimulus(1'b1, 4'hF, COM_W, 1'b0, 1'b0);
  endtask

  task automatic sendGood(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 4'h0, 32'h1234_0000 + i, 1'b0, 1'b0);
  endtask

  task automatic sendBad();
    applyStimulus(1'b1, 4'b0011, 32'h0000_0000, 1'b0, 1'b0);
  endtask

  task automatic sendIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic lockUp();
    sendCom();
    sendGood(8);
  endtask

  initial begin
    reset_n = 1'b0;
    in_active = 1'b0; in_datak = 4'h0; in_data = 32'h0; skp_err = 1'b0; stat_clr = 1'b0;
    repeat (3) @(negedge local_clk);
    checkOutput("rst_locked", {31'd0, rx_locked}, 32'd0);
    checkOutput("rst_state", {30'd0, lock_state}, 32'd0);
    checkOutput("rst_badcnt", {16'd0, bad_word_cnt}, 32'd0);
    checkOutput("rst_realign", {31'd0, realign}, 32'd0);
    checkOutput("rst_lost", {31'd0, lock_lost}, 32'd0);
    reset_n = 1'b1;

    // Acquisition: COM then eight plain data words.
    sendCom();
    checkOutput("acq_check_state", {30'd0, lock_state}, 32'd1);
    sendGood(7);
    checkOutput("acq_not_yet", {31'd0, rx_locked}, 32'd0);
    sendGood(1);
    checkOutput("acq_locked", {31'd0, rx_locked}, 32'd1);
    checkOutput("acq_state", {30'd0, lock_state}, 32'd2);
    checkOutput("acq_no_realign", {31'd0, realign}, 32'd0);

    // Leaky bucket: 3 bad, 16 good (bucket 3->2), 1 bad (->3), 1 bad drops lock.
    repeat (3) sendBad();
    checkOutput("bkt_cnt3", {16'd0, bad_word_cnt}, 32'd3);
    sendGood(16);
    sendBad();
    checkOutput("bkt_still_locked", {31'd0, rx_locked}, 32'd1);
    checkOutput("bkt_cnt4", {16'd0, bad_word_cnt}, 32'd4);
    sendBad();
    checkOutput("bkt_lost", {31'd0, lock_lost}, 32'd1);
    checkOutput("bkt_realign", {31'd0, realign}, 32'd1);
    checkOutput("bkt_unlocked", {31'd0, rx_locked}, 32'd0);
    checkOutput("bkt_cnt5", {16'd0, bad_word_cnt}, 32'd5);
    checkOutput("bkt_hunt", {30'd0, lock_state}, 32'd0);
    sendIdle(1);
    checkOutput("bkt_lost_1cyc", {31'd0, lock_lost}, 32'd0);
    checkOutput("bkt_realign_1cyc", {31'd0, realign}, 32'd0);

    // CHECK abort on a mixed-K word, after clearing the statistic.
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
    checkOutput("clr_cnt", {16'd0, bad_word_cnt}, 32'd0);
    sendCom();
    sendGood(3);
    sendBad();
    checkOutput("abort_realign", {31'd0, realign}, 32'd1);
    checkOutput("abort_hunt", {30'd0, lock_state}, 32'd0);
    checkOutput("abort_cnt", {16'd0, bad_word_cnt}, 32'd1);
    checkOutput("abort_unlocked", {31'd0, rx_locked}, 32'd0);
    sendBad();
    checkOutput("hunt_ignores_cnt", {16'd0, bad_word_cnt}, 32'd1);
    checkOutput("hunt_no_realign", {31'd0, realign}, 32'd0);

    // A COM inside CHECK restarts the good count at 1 (needs 7 more, not 3).
    sendCom();
    sendGood(5);
    sendCom();
    sendGood(6);
    checkOutput("restart_not_locked", {31'd0, rx_locked}, 32'd0);
    checkOutput("restart_check", {30'd0, lock_state}, 32'd1);
    sendGood(1);
    checkOutput("restart_locked", {31'd0, rx_locked}, 32'd1);

    // Watchdog: 1023 idle cycles survive, 1024 drop lock.
    sendIdle(1023);
    checkOutput("wd_1023_locked", {31'd0, rx_locked}, 32'd1);
    sendGood(1);
    checkOutput("wd_active_locked", {31'd0, rx_locked}, 32'd1);
    sendIdle(1023);
    checkOutput("wd_pre_lost", {31'd0, lock_lost}, 32'd0);
    sendIdle(1);
    checkOutput("wd_lost", {31'd0, lock_lost}, 32'd1);
    checkOutput("wd_realign", {31'd0, realign}, 32'd1);
    checkOutput("wd_unlocked", {31'd0, rx_locked}, 32'd0);
    checkOutput("wd_hunt", {30'd0, lock_state}, 32'd0);

    // Watchdog from CHECK: realign without lock_lost.
    sendCom();
    sendIdle(1024);
    checkOutput("wdc_realign", {31'd0, realign}, 32'd1);
    checkOutput("wdc_no_lost", {31'd0, lock_lost}, 32'd0);
    checkOutput("wdc_hunt", {30'd0, lock_state}, 32'd0);

    // SKP error on a bad word counts once in both bucket and statistic.
    lockUp();
    applyStimulus(1'b0, 4'h0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'b0011, 32'h0, 1'b1, 1'b0);
    checkOutput("skp_cnt1", {16'd0, bad_word_cnt}, 32'd1);
    checkOutput("skp_locked", {31'd0, rx_locked}, 32'd1);
    sendBad();
    sendBad();
    checkOutput("skp_bkt3_locked", {31'd0, rx_locked}, 32'd1);
    checkOutput("skp_cnt3", {16'd0, bad_word_cnt}, 32'd3);
    sendBad();
    checkOutput("skp_bkt4_lost", {31'd0, lock_lost}, 32'd1);
    checkOutput("skp_cnt4", {16'd0, bad_word_cnt}, 32'd4);

    // Saturation: preload near the top, then 20 bad events in CHECK.
    force dut.r_badWordCnt = 16'hFFF0;
    sendIdle(1);
    release dut.r_badWordCnt;
    for (int i = 0; i < 20; i++) begin
      sendCom();
      sendBad();
    end
    checkOutput("sat_ffff", {16'd0, bad_word_cnt}, 32'h0000FFFF);
    sendCom();
    applyStimulus(1'b1, 4'b0011, 32'h0, 1'b0, 1'b1);
    checkOutput("sat_clr_wins", {16'd0, bad_word_cnt}, 32'd0);
    checkOutput("sat_clr_realign", {31'd0, realign}, 32'd1);

    // Reset while locked returns to HUNT silently.
    lockUp();
    checkOutput("rl_locked", {31'd0, rx_locked}, 32'd1);
    reset_n = 1'b0;
    sendGood(1);
    checkOutput("rl_hunt", {30'd0, lock_state}, 32'd0);
    checkOutput("rl_unlocked", {31'd0, rx_locked}, 32'd0);
    checkOutput("rl_no_lost", {31'd0, lock_lost}, 32'd0);
    reset_n = 1'b1;
    sendIdle(2);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
